metaballs_n: RTL and testbench

- Clocked, parametrised successor to the two-ball metaball renderer.
- Renders NUM_BALLS bouncing metaballs: each ball's 8-bit field value is summed, the sum goes through a threshold, and the result is a 2-bit intensity.
- Sits between the VGA timing generator (x, y, display, v_sync) and the pixel output pins.
- All state runs on clk_50mhz. No derived clocks (v_sync and x[0] are not used as clocks); the pixel path is a fixed-latency pipeline.

---
 rtl/metaballs_pkg.sv | 54 +++++
 rtl/metaball_field.sv | 55 +++++
 rtl/metaballs_n.sv | 173 +++++++++++++++++
 tb/tb_metaballs_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/metaballs_pkg.sv
// rtl/metaballs_pkg.sv - shared constants, falloff table and ball state types for metaballs_n
package metaballs_pkg;

    localparam int BALL_SIZE     = 128;
    localparam int LUT_IDX_W     = 8;
    localparam int DEF_FRAC_BITS = 2;
    localparam int DEF_VEL_W     = 10;
    localparam int POS_W         = 10 + DEF_FRAC_BITS;

    localparam int DEF_THRESH_LO  = 8;
    localparam int DEF_THRESH_MID = 9;
    localparam int DEF_THRESH_HI  = 10;

    typedef logic [7:0] falloff_t [256];

    // Quadrant falloff: low nibble folds x, high nibble folds y, 15 is the ball centre.
    // Value is 500 / (2*r^2 + 3) with r measured in 4-pixel steps from the centre.
    function automatic falloff_t build_falloff();
        falloff_t t;
        for (int i = 0; i < 256; i++) begin
            int cx;
            int cy;
            cx   = 15 - (i % 16);
            cy   = 15 - (i / 16);
            t[i] = 8'(500 / (2 * (cx * cx + cy * cy) + 3));
        end
        return t;
    endfunction

    localparam falloff_t FALLOFF = build_falloff();

    typedef enum logic {
        PHYS_IDLE,
        PHYS_UPD
    } phys_state_e;

    typedef struct packed {
        logic [POS_W-1:0]            pos_x;
        logic [POS_W-1:0]            pos_y;
        logic signed [DEF_VEL_W-1:0] vel_x;
        logic signed [DEF_VEL_W-1:0] vel_y;
    } ball_state_t;

    // Step velocity one unit toward the centre, clamped at +/-lim.
    function automatic logic signed [DEF_VEL_W-1:0] vel_step(
        input logic signed [DEF_VEL_W-1:0] v,
        input logic                        up,
        input logic signed [DEF_VEL_W-1:0] lim
    );
        if (up) return (v == lim) ? v : v + DEF_VEL_W'(1);
        return (v == -lim) ? v : v - DEF_VEL_W'(1);
    endfunction

endpackage

// File: rtl/metaball_field.sv
// rtl/metaball_field.sv - per-ball box test, quadrant fold and registered falloff lookup
module metaball_field
    import metaballs_pkg::*;
(
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic [7:0] field
);

    logic [10:0]          dx_w;
    logic [10:0]          dy_w;
    logic                 in_box;
    logic [6:0]           dx_q;
    logic [6:0]           dy_q;
    logic                 in_box_q;
    logic [LUT_IDX_W-1:0] lut_idx;

    // S1 combinational: offsets at 11 bits so ball_x+128 past 1023 cannot alias
    always_comb begin
        dx_w   = {1'b0, x} - {1'b0, ball_x};
        dy_w   = {1'b0, y} - {1'b0, ball_y};
        in_box = (x >= ball_x) && (y >= ball_y) &&
                 (dx_w < 11'(BALL_SIZE)) && (dy_w < 11'(BALL_SIZE));
    end

    // S1 register: offsets inside the box and the box hit
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            dx_q     <= '0;
            dy_q     <= '0;
            in_box_q <= 1'b0;
        end else begin
            dx_q     <= dx_w[6:0];
            dy_q     <= dy_w[6:0];
            in_box_q <= in_box;
        end
    end

    // S2 combinational: fold the far half of each axis back onto the near quadrant
    always_comb begin
        lut_idx = {dy_q[6] ? ~dy_q[5:2] : dy_q[5:2],
                   dx_q[6] ? ~dx_q[5:2] : dx_q[5:2]};
    end

    // S2 register: field value, zero outside the ball box
    always_ff @(posedge clk_50mhz) begin
        if (reset) field <= '0;
        else       field <= in_box_q ? FALLOFF[lut_idx] : 8'd0;
    end

endmodule

// File: rtl/metaballs_n.sv
// rtl/metaballs_n.sv - NUM_BALLS metaball renderer with per-frame motion; METABALLS_FREEZE_EN adds freeze input
module metaballs_n
    import metaballs_pkg::*;
#(
    parameter int NUM_BALLS     = 4,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int FRAC_BITS     = DEF_FRAC_BITS,
    parameter int VEL_W         = DEF_VEL_W,
    parameter int THRESH_LO     = DEF_THRESH_LO,
    parameter int THRESH_MID    = DEF_THRESH_MID,
    parameter int THRESH_HI     = DEF_THRESH_HI
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       display,
    input  logic       v_sync,
`ifdef METABALLS_FREEZE_EN
    input  logic       freeze,
`endif
    output logic [1:0] rgb,
    output logic       phys_busy
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int SUM_W = 8 + $clog2(NUM_BALLS + 1);
    localparam logic [POS_W-1:0] CENTRE_X =
        POS_W'(((SCREEN_WIDTH - BALL_SIZE) / 2) << FRAC_BITS);
    localparam logic [POS_W-1:0] CENTRE_Y =
        POS_W'(((SCREEN_HEIGHT - BALL_SIZE) / 2) << FRAC_BITS);
    localparam logic signed [DEF_VEL_W-1:0] VEL_LIM =
        DEF_VEL_W'((1 << (VEL_W - 1)) - 1);

    // Balls start spread across the screen, y order permuted so they do not line up.
    function automatic ball_state_t start_state(input int i);
        ball_state_t s;
        s.pos_x = POS_W'(((SCREEN_WIDTH - BALL_SIZE) * (i + 1) / (NUM_BALLS + 1)) << FRAC_BITS);
        s.pos_y = POS_W'(((SCREEN_HEIGHT - BALL_SIZE) * (((3 * i) % NUM_BALLS) + 1)
                          / (NUM_BALLS + 1)) << FRAC_BITS);
        s.vel_x = '0;
        s.vel_y = '0;
        return s;
    endfunction

    ball_state_t balls [NUM_BALLS];
    ball_state_t cur_ball;
    ball_state_t nxt_ball;
    logic [POS_W-1:0] nxt_x;
    logic [POS_W-1:0] nxt_y;

    phys_state_e state;
    phys_state_e state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic upd_en;

    logic v_sync_q;
    logic tick;
    logic tick_ok;

    logic [7:0]       field [NUM_BALLS];
    logic             disp_d1;
    logic             disp_d2;
    logic [SUM_W-1:0] sum;
    logic [1:0]       level;

    // Frame tick on the falling edge of v_sync
    always_ff @(posedge clk_50mhz) begin
        if (reset) v_sync_q <= 1'b0;
        else       v_sync_q <= v_sync;
    end

    assign tick = v_sync_q & ~v_sync;
`ifdef METABALLS_FREEZE_EN
    assign tick_ok = tick & ~freeze;
`else
    assign tick_ok = tick;
`endif

    // Motion FSM state register
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state <= PHYS_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Motion FSM: one ball per cycle, ticks ignored until the sweep ends
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        upd_en    = 1'b0;
        phys_busy = 1'b0;
        case (state)
            PHYS_IDLE: begin
                if (tick_ok) begin
                    state_nx = PHYS_UPD;
                    idx_nx   = '0;
                end
            end
            PHYS_UPD: begin
                upd_en    = 1'b1;
                phys_busy = 1'b1;
                if (idx == IDX_W'(NUM_BALLS - 1)) state_nx = PHYS_IDLE;
                else                              idx_nx   = idx + IDX_W'(1);
            end
            default: state_nx = PHYS_IDLE;
        endcase
    end

    // Next state of the ball being swept: move, then accelerate toward the centre
    always_comb begin
        cur_ball       = balls[idx];
        nxt_x          = cur_ball.pos_x +
                         {{(POS_W-DEF_VEL_W){cur_ball.vel_x[DEF_VEL_W-1]}}, cur_ball.vel_x};
        nxt_y          = cur_ball.pos_y +
                         {{(POS_W-DEF_VEL_W){cur_ball.vel_y[DEF_VEL_W-1]}}, cur_ball.vel_y};
        nxt_ball.pos_x = nxt_x;
        nxt_ball.pos_y = nxt_y;
        nxt_ball.vel_x = vel_step(cur_ball.vel_x, nxt_x < CENTRE_X, VEL_LIM);
        nxt_ball.vel_y = vel_step(cur_ball.vel_y, nxt_y < CENTRE_Y, VEL_LIM);
    end

    // Ball state storage
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) balls[i] <= start_state(i);
        end else if (upd_en) begin
            balls[idx] <= nxt_ball;
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_field
        metaball_field u_field (
            .clk_50mhz (clk_50mhz),
            .reset     (reset),
            .x         (x),
            .y         (y),
            .ball_x    (balls[g].pos_x[POS_W-1:FRAC_BITS]),
            .ball_y    (balls[g].pos_y[POS_W-1:FRAC_BITS]),
            .field     (field[g])
        );
    end

    // S3 combinational: total field and threshold into an intensity level
    always_comb begin
        sum = '0;
        for (int g = 0; g < NUM_BALLS; g++) sum = sum + SUM_W'(field[g]);
        if      (sum > SUM_W'(THRESH_HI))  level = 2'd3;
        else if (sum > SUM_W'(THRESH_MID)) level = 2'd2;
        else if (sum > SUM_W'(THRESH_LO))  level = 2'd1;
        else                               level = 2'd0;
    end

    // Display flag pipeline and S3 output register
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            disp_d1 <= 1'b0;
            disp_d2 <= 1'b0;
            rgb     <= 2'd0;
        end else begin
            disp_d1 <= display;
            disp_d2 <= disp_d1;
            rgb     <= disp_d2 ? level : 2'd0;
        end
    end

endmodule

// File: tb/tb_metaballs_n.sv
// tb/tb_metaballs_n.sv - self-checking bench for metaballs_n
module tb_metaballs_n;

    localparam int NB  = 4;
    localparam int CXP = ((800 - 128) / 2) * 4;
    localparam int CYP = ((600 - 128) / 2) * 4;

    logic       clk_50mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] x         = '0;
    logic [9:0] y         = '0;
    logic       display   = 1'b0;
    logic       v_sync    = 1'b1;
`ifdef METABALLS_FREEZE_EN
    logic       freeze    = 1'b0;
`endif
    logic [1:0] rgb;
    logic [1:0] rgb1;
    logic       phys_busy;
    logic       phys_busy1;

    int vectors     = 0;
    int miscompares = 0;

    int mpx [NB];
    int mpy [NB];
    int mvx [NB];
    int mvy [NB];

    typedef struct {
        int         px;
        int         py;
        logic       disp;
        int         exp_rgb;
    } vec_t;

    always #10 clk_50mhz = ~clk_50mhz;

    metaballs_n dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .display   (display),
        .v_sync    (v_sync),
`ifdef METABALLS_FREEZE_EN
        .freeze    (freeze),
`endif
        .rgb       (rgb),
        .phys_busy (phys_busy)
    );

    metaballs_n #(.NUM_BALLS(1)) dut1 (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .display   (display),
        .v_sync    (v_sync),
`ifdef METABALLS_FREEZE_EN
        .freeze    (freeze),
`endif
        .rgb       (rgb1),
        .phys_busy (phys_busy1)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            mpx[i] = ((800 - 128) * (i + 1) / (NB + 1)) * 4;
            mpy[i] = ((600 - 128) * (((3 * i) % NB) + 1) / (NB + 1)) * 4;
            mvx[i] = 0;
            mvy[i] = 0;
        end
    endfunction

    function automatic void step_axis(inout int p, inout int v, input int c);
        int n;
        n = (p + v) & 4095;
        p = n;
        if (n < c) v = (v < 511) ? v + 1 : 511;
        else       v = (v > -511) ? v - 1 : -511;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NB; i++) begin
            step_axis(mpx[i], mvx[i], CXP);
            step_axis(mpy[i], mvy[i], CYP);
        end
    endfunction

    // Field of one ball: distance from its centre in 4-pixel steps, mirrored per half
    function automatic int field_of(input int px, input int py, input int bx, input int by);
        int dx, dy, ex, ey, rx, ry;
        dx = px - bx;
        dy = py - by;
        if (dx < 0 || dy < 0 || dx >= 128 || dy >= 128) return 0;
        ex = (dx < 64) ? dx / 4 : (127 - dx) / 4;
        ey = (dy < 64) ? dy / 4 : (127 - dy) / 4;
        rx = 15 - ex;
        ry = 15 - ey;
        return 500 / (2 * (rx * rx + ry * ry) + 3);
    endfunction

    function automatic int model_rgb(input int px, input int py, input bit d);
        int s;
        if (!d) return 0;
        s = 0;
        for (int i = 0; i < NB; i++) s += field_of(px, py, mpx[i] / 4, mpy[i] / 4);
        return (s > 10) ? 3 : (s > 9) ? 2 : (s > 8) ? 1 : 0;
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < NB; i++) begin
            check({tag, "_pos_x"}, int'(dut.balls[i].pos_x), mpx[i]);
            check({tag, "_pos_y"}, int'(dut.balls[i].pos_y), mpy[i]);
            check({tag, "_vel_x"}, int'($signed(dut.balls[i].vel_x)), mvx[i]);
            check({tag, "_vel_y"}, int'($signed(dut.balls[i].vel_y)), mvy[i]);
        end
    endtask

    task automatic run_pixels(input int n, input string tag);
        int ex [$];
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk_50mhz);
            if (k >= 3) check(tag, int'(rgb), ex[k-3]);
            if (k < n) begin
                int j, px, py;
                bit d;
                j  = $urandom_range(0, NB - 1);
                px = (mpx[j] / 4 + $urandom_range(0, 140) - 6) & 1023;
                py = (mpy[j] / 4 + $urandom_range(0, 140) - 6) & 1023;
                d  = ($urandom_range(0, 7) != 0);
                x       = 10'(px);
                y       = 10'(py);
                display = d;
                ex.push_back(model_rgb(px, py, d));
            end
        end
    endtask

    task automatic frame_tick(input int exp_busy, input int exp_busy1, input string tag);
        int cnt, cnt1;
        cnt  = 0;
        cnt1 = 0;
        @(negedge clk_50mhz);
        v_sync = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_50mhz);
            if (phys_busy)  cnt++;
            if (phys_busy1) cnt1++;
        end
        v_sync = 1'b1;
        check({tag, "_busy"}, cnt, exp_busy);
        check({tag, "_busy1"}, cnt1, exp_busy1);
        @(negedge clk_50mhz);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        vec_t vt [8];
        int   cnt;

        // Single-ball instance: ball sits at (336,236)
        vt[0] = '{399, 299, 1'b1, 3};
        vt[1] = '{400, 300, 1'b1, 3};
        vt[2] = '{464, 299, 1'b1, 0};
        vt[3] = '{335, 299, 1'b1, 0};
        vt[4] = '{399, 299, 1'b0, 0};
        vt[5] = '{380, 288, 1'b1, 3};
        vt[6] = '{384, 280, 1'b1, 1};
        vt[7] = '{376, 288, 1'b1, 0};

        model_reset();
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        reset = 1'b0;

        check("rst_rgb", int'(rgb), 0);
        check("rst_busy", int'(phys_busy), 0);
        check_state("rst");
        check("rst_b0_pos_x", int'(dut.balls[0].pos_x), 134 << 2);

        x = 10'd790;
        y = 10'd590;
        display = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        check("far_rgb", int'(rgb), 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50mhz);
            x       = 10'(vt[i].px);
            y       = 10'(vt[i].py);
            display = vt[i].disp;
            repeat (3) @(negedge clk_50mhz);
            check($sformatf("tbl%0d_rgb", i), int'(rgb1), vt[i].exp_rgb);
        end

        run_pixels(150, "px_start");

        frame_tick(NB, 1, "tick1");
        model_tick();
        check_state("tick1");
        check("tick1_b0_vel_x", int'($signed(dut.balls[0].vel_x)), 1);
        check("tick1_b0_pos_x", int'(dut.balls[0].pos_x), 536);

        // Second falling edge lands while the sweep is running
        cnt = 0;
        @(negedge clk_50mhz);
        v_sync = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_50mhz);
            if (phys_busy) cnt++;
            if (c == 0) v_sync = 1'b1;
            if (c == 1) v_sync = 1'b0;
            if (c == 12) v_sync = 1'b1;
        end
        check("dbl_tick_busy", cnt, NB);
        model_tick();
        check_state("dbl_tick");

        for (int t = 0; t < 6; t++) begin
            frame_tick(NB, 1, "tickn");
            model_tick();
        end
        check_state("tickn");
        run_pixels(200, "px_moved");

        // Reset during the second UPD cycle
        @(negedge clk_50mhz);
        v_sync = 1'b0;
        @(negedge clk_50mhz);
        check("midrst_busy_c1", int'(phys_busy), 1);
        @(negedge clk_50mhz);
        check("midrst_busy_c2", int'(phys_busy), 1);
        reset = 1'b1;
        @(negedge clk_50mhz);
        check("midrst_busy", int'(phys_busy), 0);
        model_reset();
        check_state("midrst");
        reset  = 1'b0;
        v_sync = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        check("midrst_idle_busy", int'(phys_busy), 0);

`ifdef METABALLS_FREEZE_EN
        frame_tick(NB, 1, "pre_frz");
        model_tick();
        frame_tick(NB, 1, "pre_frz");
        model_tick();
        freeze = 1'b1;
        for (int t = 0; t < 3; t++) frame_tick(0, 0, "frz");
        check_state("frz");
        run_pixels(60, "px_frz");
        freeze = 1'b0;
        frame_tick(NB, 1, "post_frz");
        model_tick();
        check_state("post_frz");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
